// File: rtl/arb_pkg.sv
// Shared arbitration types: FSM state encoding and index-width helper.
// Used by rr_arbiter_n and the mux_n_to_1 it drives.
package arb_pkg;

  localparam logic ARB_IDLE  = 1'b0;
  localparam logic ARB_GRANT = 1'b1;

  typedef enum logic {
    S_IDLE  = ARB_IDLE,
    S_GRANT = ARB_GRANT
  } arb_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter_n_if.sv
// Requester-side bundle of the round-robin arbiter.
// Requesters use master; the arbiter uses slave.
interface rr_arbiter_n_if
  import arb_pkg::*;
#(
  parameter int N = 8
);

  localparam int IW = idx_w(N);

  logic [N-1:0]  req;
  logic [N-1:0]  grant;
  logic [IW-1:0] grant_idx;
  logic          grant_valid;
  logic          timeout;

  modport master (
    output req,
    input  grant,
    input  grant_idx,
    input  grant_valid,
    input  timeout
  );

  modport slave (
    input  req,
    output grant,
    output grant_idx,
    output grant_valid,
    output timeout
  );

endinterface

// File: rtl/rr_pick_n.sv
// Combinational round-robin pick: first set request at or
// above ptr, searching upward with wrap-around modulo N.
module rr_pick_n
  import arb_pkg::*;
#(
  parameter  int N  = 8,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] idx,
  output logic          any
);

  localparam logic [IW:0] NN = (IW+1)'(N);

  logic [N-1:0]  rot;
  logic [IW-1:0] off;
  logic [IW:0]   sum;

  always_comb begin
    rot = N'({req, req} >> ptr);
    off = '0;
    any = |req;
    // descending scan leaves the lowest set bit
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = IW'(i);
    end
    sum = {1'b0, off} + {1'b0, ptr};
    if (sum >= NN) sum = sum - NN;
    idx  = sum[IW-1:0];
    pick = any ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/rr_arbiter_n.sv
// Round-robin arbiter with hold timeout; grant_idx drives the
// shared mux select and stays stable between grants.
module rr_arbiter_n
  import arb_pkg::*;
#(
  parameter int N        = 8,
  parameter int MAX_HOLD = 16
) (
  input logic           clk,
  input logic           rst_n,
  rr_arbiter_n_if.slave bus
);

  localparam int IW = idx_w(N);
  localparam int CW =
    (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CW-1:0] HOLD_LAST =
    CW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam bit TMO_EN = (MAX_HOLD != 0);

  arb_state_t    state_q, state_nx;
  logic [N-1:0]  grant_q, grant_nx;
  logic [IW-1:0] idx_q, idx_nx;
  logic          valid_q, valid_nx;
  logic          tmo_q, tmo_nx;
  logic [IW-1:0] ptr_q, ptr_nx;
  logic [CW-1:0] cnt_q, cnt_nx;

  logic [N-1:0]  pick;
  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic          rel;
  logic          hit;
  logic [IW-1:0] ptr_adv;

  rr_pick_n #(.N(N)) u_pick (
    .req  (bus.req),
    .ptr  (ptr_q),
    .pick (pick),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // release wins over a coincident expiry
  assign rel = !bus.req[idx_q];
  assign hit = TMO_EN && !rel && (cnt_q == HOLD_LAST);
  assign ptr_adv =
    (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);

  always_comb begin
    state_nx = state_q;
    grant_nx = grant_q;
    idx_nx   = idx_q;
    valid_nx = valid_q;
    tmo_nx   = 1'b0;
    ptr_nx   = ptr_q;
    cnt_nx   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (pick_any) begin
          state_nx = S_GRANT;
          grant_nx = pick;
          idx_nx   = pick_idx;
          valid_nx = 1'b1;
          cnt_nx   = '0;
        end
      end
      S_GRANT: begin
        unique case (1'b1)
          rel, hit: begin
            state_nx = S_IDLE;
            grant_nx = '0;
            valid_nx = 1'b0;
            ptr_nx   = ptr_adv;
            tmo_nx   = hit;
          end
          default: cnt_nx = cnt_q + CW'(1);
        endcase
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      tmo_q   <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nx;
      grant_q <= grant_nx;
      idx_q   <= idx_nx;
      valid_q <= valid_nx;
      tmo_q   <= tmo_nx;
      ptr_q   <= ptr_nx;
      cnt_q   <= cnt_nx;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_idx   = idx_q;
  assign bus.grant_valid = valid_q;
  assign bus.timeout     = tmo_q;

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Scoreboard bench for rr_arbiter_n (N=4, MAX_HOLD=4) with a
// holder/ptr reference model, directed scenarios and random req.
module tb_rr_arbiter_n;

  localparam int N  = 4;
  localparam int MH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rr_arbiter_n_if #(.N(N)) bus ();

  rr_arbiter_n #(.N(N), .MAX_HOLD(MH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [3:0] grant;
    logic [1:0] idx;
    logic       valid;
    logic       tmo;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  int holder   = -1;
  int held     = 0;
  int ptr      = 0;
  int last_idx = 0;
  bit tmo      = 1'b0;

  int   order[$];
  int   exp_q[$];
  int   n_tmo = 0;
  logic prev_valid = 1'b0;
  logic [3:0] r;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic check_order(input string nm);
    check({nm, "_count"}, order.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < order.size())
        check({nm, "_grant"}, order[i], exp_q[i]);
    end
  endtask

  function automatic void model_reset();
    holder   = -1;
    held     = 0;
    ptr      = 0;
    last_idx = 0;
    tmo      = 1'b0;
  endfunction

  // One rising edge of the arbiter as seen from outside
  function automatic void model_step(input logic [3:0] rq);
    tmo = 1'b0;
    if (holder < 0) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (ptr + k) % N;
        if (rq[c]) begin
          holder   = c;
          held     = 1;
          last_idx = c;
          break;
        end
      end
    end else if (!rq[holder]) begin
      ptr    = (holder + 1) % N;
      holder = -1;
    end else if (MH != 0 && held == MH) begin
      ptr    = (holder + 1) % N;
      holder = -1;
      tmo    = 1'b1;
    end else begin
      held++;
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.grant = (holder >= 0) ? 4'(1 << holder) : 4'b0;
    e.idx   = 2'(last_idx);
    e.valid = (holder >= 0);
    e.tmo   = tmo;
    return e;
  endfunction

  task automatic step(input logic [3:0] rq);
    bus.req = rq;
    @(posedge clk);
    if (rst_n) model_step(rq);
    sb.push_back(model_out());
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("grant", bus.grant, mon_e.grant);
        check("grant_idx", bus.grant_idx, mon_e.idx);
        check("grant_valid", bus.grant_valid, mon_e.valid);
        check("timeout", bus.timeout, mon_e.tmo);
      end
      if (bus.grant_valid && !prev_valid)
        order.push_back(int'(bus.grant_idx));
      if (bus.timeout) n_tmo++;
      prev_valid = bus.grant_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.req = '0;
    model_reset();
    repeat (3) step(4'b0000);
    #2 rst_n = 1'b1;

    // idle with no requests
    repeat (10) step(4'b0000);
    settle();
    check("idle_grants", order.size(), 0);
    check("idle_tmo", n_tmo, 0);

    // rotation: each holder drops after two cycles
    order.delete();
    for (int c = 0; c < 14; c++) begin
      r = 4'b1111;
      if (holder >= 0 && held == 2) r[holder] = 1'b0;
      step(r);
    end
    step(4'b0000);
    step(4'b0000);
    settle();
    exp_q = '{0, 1, 2, 3, 0};
    check_order("rotation");

    // pointer skip and wrap
    order.delete();
    step(4'b0100);
    step(4'b0000);
    step(4'b0101);
    step(4'b0000);
    step(4'b0101);
    step(4'b0000);
    step(4'b0000);
    settle();
    exp_q = '{2, 0, 2};
    check_order("skip_wrap");

    // timeout rotation between two holders
    order.delete();
    n_tmo = 0;
    repeat (12) step(4'b0011);
    step(4'b0000);
    step(4'b0000);
    settle();
    exp_q = '{0, 1, 0};
    check_order("timeout");
    check("timeout_pulses", n_tmo, 2);

    // release coinciding with expiry
    order.delete();
    n_tmo = 0;
    for (int c = 0; c < 8; c++) begin
      r = 4'b0010;
      if (holder == 1 && held == MH) r = 4'b0000;
      step(r);
    end
    step(4'b0000);
    step(4'b0000);
    settle();
    exp_q = '{1, 1};
    check_order("rel_tmo");
    check("rel_tmo_pulses", n_tmo, 0);

    // asynchronous reset in the middle of a grant
    step(4'b0100);
    step(4'b0100);
    #2 rst_n = 1'b0;
    #1;
    check("async_grant", bus.grant, 4'b0000);
    check("async_valid", bus.grant_valid, 1'b0);
    model_reset();
    sb.delete();
    sb.push_back(model_out());
    repeat (2) step(4'b0100);
    #2 rst_n = 1'b1;
    order.delete();
    step(4'b1100);
    step(4'b0000);
    step(4'b0000);
    settle();
    exp_q = '{2};
    check_order("post_reset");

    // random level-held requests
    r = 4'b0000;
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
      end
      if (holder >= 0 && $urandom_range(0, 5) == 0)
        r[holder] = 1'b0;
      step(r);
    end
    repeat (3) step(4'b0000);
    settle();
    check("sb_drain", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_n.md
# rr_arbiter_n

Round-robin arbiter sharing one `mux_n_to_1` datapath among N requesters. It grants exactly one requester at a time and holds the grant until that requester releases it or a hold timeout expires. `grant_idx` drives the mux `sel` port directly, and `grant` (one-hot) goes back to the requesters. It sits between the requester blocks and the shared mux.

## Interface
- `N`, 8: number of requesters; legal range 2..8, same as the mux it drives.
- `MAX_HOLD`, 16: maximum consecutive cycles one grant is held; 0 disables the timeout.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req` input N: request per requester; level-sensitive, held high for as long as the requester wants the resource.
- `grant` output N: one-hot grant; all zeros when no grant is active.
- `grant_idx` output $clog2(N): binary index of the granted requester; connects to mux `sel`.
- `grant_valid` output 1: a grant is active; equals OR-reduction of `grant`.
- `timeout` output 1: one-cycle pulse when a grant is revoked by `MAX_HOLD` expiry.

## Operation
- Two states: IDLE and GRANT.
- Reset values: state IDLE; `grant`=0; `grant_idx`=0; `grant_valid`=0; `timeout`=0; round-robin pointer `ptr`=0; hold counter=0.
- **IDLE:**
  - If `req`≠0, select the first set bit at or above `ptr`, searching upward with wrap-around modulo N.
  - Register the one-hot `grant` and `grant_idx`, set `grant_valid`, clear the hold counter, go to GRANT.
  - If `req`=0, remain in IDLE with all outputs at their reset values; `ptr` is unchanged.
- **GRANT:**
  - The hold counter increments each cycle.
  - Normal release: the holder's `req` bit sampled low. Go to IDLE, clear `grant`/`grant_valid`, set `ptr`=(`grant_idx`+1) mod N.
  - Timeout: `MAX_HOLD`≠0, hold counter == `MAX_HOLD`−1, and the holder's `req` still high. Same transition as normal release, plus `timeout`=1 for that one cycle.
  - Requests from non-holders are ignored while in GRANT. They are never lost, because `req` is level-held.
- `grant_idx` keeps its last value in IDLE, so the mux select is stable between grants.
- Pointer wrap: a grant to N−1 sets `ptr`=0.
- A requester revoked by timeout that keeps `req` high competes normally. It is re-granted only after every other active requester has been served in rotation.
- Simultaneous timeout and holder release in the same cycle: treated as a normal release, with `timeout`=0.
- If `rst_n` is asserted mid-grant, all outputs drop to reset values immediately (asynchronously). The first grant after deassertion starts the search from index 0.
- Hold counter width: $clog2(MAX_HOLD+1); minimum 1 bit when `MAX_HOLD`=0.

## Timing
- Grant latency: `req` first sampled high at edge k while in IDLE → `grant`/`grant_valid` high after edge k.
- Release: holder `req` sampled low at edge m → `grant_valid` low after edge m.
- Turnaround: the earliest next grant is after edge m+1, giving one mandatory idle cycle between grants. The mux select never changes while `grant_valid` is high.
- Maximum grant length: `MAX_HOLD` cycles of `grant_valid`=1, then `timeout` is high for the cycle after the last held cycle.
- All outputs are registered; there is no combinational path from `req` to any output.

## Structure
- Shared package `arb_pkg` holds:
  - state encoding localparams `ARB_IDLE`=1'b0 and `ARB_GRANT`=1'b1;
  - an index-width helper constant used by both this block and `mux_n_to_1`.
- Sub-module `rr_pick_n` (combinational): inputs `req` and `ptr`; outputs the one-hot pick, its binary index, and `any`. Implementation: rotate `req` right by `ptr`, take the first set bit from the LSB, rotate back.
- The top level contains the FSM, pointer, hold counter, and output registers.

## Test plan
- Reset and idle: N=4, `req`=0 for 10 cycles → `grant`=0, `grant_valid`=0, `grant_idx`=0, `timeout`=0 throughout.
- Rotation: N=4, `req`=4'b1111 held; each holder drops its bit for one cycle after 2 granted cycles, then reasserts. Required grant order: 0, 1, 2, 3, 0, with one idle cycle between grants.
- Pointer skip and wrap: N=4, `ptr`=3 after a grant to 2; `req`=4'b0101 → grant goes to 0 (`grant_idx`=0), then `ptr`=1.
- Timeout: N=4, `MAX_HOLD`=4, `req`=4'b0011 held. Required:
  - `grant`=4'b0001 for exactly 4 cycles;
  - `timeout` pulses once;
  - one idle cycle;
  - `grant`=4'b0010 for 4 cycles, `timeout` pulse;
  - back to 4'b0001.
- Release and timeout in the same cycle: `MAX_HOLD`=4; holder drops `req` on its 4th cycle → `timeout`=0, normal transition to IDLE.
- Async reset mid-grant: assert `rst_n`=0 between clock edges while `grant`=4'b0100 → `grant`=0 and `grant_valid`=0 without waiting for a clock edge. After release, `req`=4'b1100 → grant goes to 2 (search from `ptr`=0).
